id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage of the 5-stage CPU. It registers decoded operands and control from ID and drives the operand/control inputs of the combinational ALU in EX (`a`, `b`, 4-bit `control`). It contains the EX-side operand bypass and the RAW/load-use hazard detector that holds IF/ID and injects bubbles.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_AW  source/destination indices
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_use_imm  in  1  ALU b = immediate
- id_alu_ctrl  in  4  ALU control encoding
- id_reg_write, id_mem_read, id_mem_write  in  1  stage control
- flush  in  1  kill ID/EX contents (branch taken)
- hold  in  1  freeze ID/EX (downstream busy)
- mem_rd  in  REG_AW;  mem_reg_write  in  1;  mem_fwd_data  in  XLEN  EX/MEM bypass source
- wb_rd  in  REG_AW;  wb_reg_write  in  1;  wb_fwd_data  in  XLEN  MEM/WB bypass source
- ex_a, ex_b  out  XLEN  ALU operands
- ex_alu_ctrl  out  4  ALU control
- ex_store_data  out  XLEN  bypassed rs2 for sw
- ex_rd  out  REG_AW;  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1
- hazard_stall  out  1  hold PC and IF/ID this cycle

## Operation
- State is one ID/EX register: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, use_imm, alu_ctrl, reg_write, mem_read, mem_write.
- Register update priority: rst > flush > hold > hazard_stall > load.
  - rst or flush: valid, reg_write, mem_read and mem_write clear to 0; alu_ctrl clears to 0000.
  - hold: all fields keep their value.
  - hazard_stall (without hold): load a bubble, with the same values as flush.
  - otherwise: load ID fields; valid = id_valid.
- Bypass (combinational from register outputs), per source rs:
  - If rs==0: use register data.
  - Else if mem_reg_write and mem_rd==rs: use mem_fwd_data.
  - Else if wb_reg_write and wb_rd==rs: use wb_fwd_data.
  - Else: use register data.
- ex_a = bypassed rs1.
- ex_b = imm when use_imm, else bypassed rs2.
- ex_store_data = bypassed rs2 always.
- Load-use: hazard_stall=1 when id_valid, the registered instruction is valid with mem_read=1, rd!=0, and rd equals id_rs1 or id_rs2.
  - Match on id_rs2 counts even when id_use_imm=1 (conservative).
- Register file is write-before-read; WB-stage writes never cause hazards in ID.
- Bubble and reset outputs all drive 0.

## Timing
- Latency: ID fields appear on ex_* one cycle after capture.
- Bypass adds no cycles.
- Load-use costs exactly one bubble. The following cycle the load sits in MEM, so the value arrives through the MEM/WB path one cycle later.
- hazard_stall is combinational from ID inputs and register state. It is asserted in the same cycle as the conflict.
- Reset is asynchronous: register outputs go to 0 immediately. First load happens on the first edge after rst deasserts.
- flush and hazard_stall in the same cycle: the bubble is loaded, and hazard_stall still reflects the combinational condition.
- hold and hazard in the same cycle: the register holds, and hazard_stall stays asserted.

## Configuration
- FORWARDING_EN defined:
  - Bypass muxes present.
  - hazard_stall covers load-use only.
- FORWARDING_EN undefined:
  - ex_a and ex_b come straight from register data.
  - hazard_stall additionally asserts when id_valid and id_rs1 or id_rs2 (nonzero) matches either of:
    - the registered rd with reg_write and valid;
    - mem_rd with mem_reg_write.
  - mem_fwd_data and wb_fwd_data are unused.

## Structure
- Shared package cpu_pkg:
  - ALU control constants: ALU_AND=0000, ALU_XOR=0001, ALU_SLL=0010, ALU_ADD=0011, ALU_SUB=0100, ALU_MUL=0101, ALU_SRA=0110.
  - XLEN and REG_AW defaults.
  - Bubble constant for the control fields.
- One sub-module, fwd_unit: the per-operand bypass select, instantiated twice and compiled only under FORWARDING_EN.
- Hazard detection stays inline.

## Test plan
- Reset mid-stream: assert rst with a valid instruction registered -> ex_valid=0, ex_reg_write=0, ex_alu_ctrl=0000 immediately, before any clock edge.
- Back-to-back add: add x3,x1,x2 in EX/MEM (mem_fwd_data=0x10), next instruction reads x3 with x3 stale=0x5 -> ex_a=0x10. With FORWARDING_EN undefined -> hazard_stall=1 for 2 cycles, then ex_a=0x10 from the register file.
- Dual match: x4 written in both MEM (0xAA) and WB (0xBB) -> ex_a=0xAA.
- x0 write: mem_rd=0 with mem_reg_write=1 and mem_fwd_data=0xFF, instruction reading x0 -> ex_a=0.
- Load-use: lw x5 registered, ID is add x6,x5,x1 -> hazard_stall=1 for one cycle, next cycle is a bubble, then the add enters with x5 bypassed from WB.
- Flush+hold: flush=1 and hold=1 together -> bubble loaded. hold alone for 3 cycles -> all ex_* outputs unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: default widths, ALU control encodings and the
// control-field bubble used by the ID/EX stage.
package cpu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_XOR = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;

  // Control bits travelling with an instruction into EX
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_imm;
    logic [3:0] alu_ctrl;
  } ex_ctrl_t;

  // A bubble is an all-zero control word: no writeback, no memory access
  localparam ex_ctrl_t CTRL_BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    use_imm:   1'b0,
    alu_ctrl:  ALU_AND
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, pipeline control, bypass sources in;
// ALU operands, EX control and hazard stall out.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
  logic              id_use_imm;
  logic [3:0]        id_alu_ctrl;
  logic              id_reg_write, id_mem_read, id_mem_write;
  logic              flush, hold;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic [XLEN-1:0]   mem_fwd_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic [XLEN-1:0]   wb_fwd_data;
  logic [XLEN-1:0]   ex_a, ex_b, ex_store_data;
  logic [3:0]        ex_alu_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic              hazard_stall;

  // Upstream / surrounding pipeline side
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
           flush, hold, mem_rd, mem_reg_write, mem_fwd_data,
           wb_rd, wb_reg_write, wb_fwd_data,
    input  ex_a, ex_b, ex_store_data, ex_alu_ctrl, ex_rd, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );

  // The ID/EX stage itself
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
           flush, hold, mem_rd, mem_reg_write, mem_fwd_data,
           wb_rd, wb_reg_write, wb_fwd_data,
    output ex_a, ex_b, ex_store_data, ex_alu_ctrl, ex_rd, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );
endinterface

// File: rtl/fwd_unit.sv
// Per-operand bypass select. The nearer producer (EX/MEM) wins over
// MEM/WB; x0 is never bypassed since it is hardwired to zero.
module fwd_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   data
);

  // Priority mux: x0, then MEM, then WB, then register data
  always_comb begin
    data = reg_data;
    if (rs == '0)                             data = reg_data;
    else if (mem_reg_write && mem_rd == rs)   data = mem_data;
    else if (wb_reg_write && wb_rd == rs)     data = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand bypass and hazard detection.
// FORWARDING_EN: when defined, bypass muxes feed the ALU and only load-use
// stalls; when undefined, operands come straight from register data and any
// RAW on an in-flight (EX or MEM) writer stalls ID.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  ex_ctrl_t          ctrl_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
  logic [XLEN-1:0]   rs1_byp, rs2_byp;
  logic              load_use, raw_hit, stall;
  logic              kill;

  // Load-use: the load's data is not ready until it leaves MEM
  always_comb begin
    load_use = bus.id_valid && ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) &&
               ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));
  end

`ifdef FORWARDING_EN
  assign raw_hit = 1'b0;

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs(rs1_q), .reg_data(rs1_data_q),
    .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write), .mem_data(bus.mem_fwd_data),
    .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .wb_data(bus.wb_fwd_data),
    .data(rs1_byp)
  );

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs(rs2_q), .reg_data(rs2_data_q),
    .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write), .mem_data(bus.mem_fwd_data),
    .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .wb_data(bus.wb_fwd_data),
    .data(rs2_byp)
  );
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.mem_fwd_data, bus.wb_fwd_data, bus.wb_rd, bus.wb_reg_write};

  assign rs1_byp = rs1_data_q;
  assign rs2_byp = rs2_data_q;

  // Without bypass, any nonzero source written by EX or MEM must wait;
  // WB writes land in the register file before ID reads it.
  always_comb begin
    raw_hit = 1'b0;
    if (bus.id_valid) begin
      if (bus.id_rs1 != '0 &&
          ((ctrl_q.valid && ctrl_q.reg_write && rd_q == bus.id_rs1) ||
           (bus.mem_reg_write && bus.mem_rd == bus.id_rs1)))
        raw_hit = 1'b1;
      if (bus.id_rs2 != '0 &&
          ((ctrl_q.valid && ctrl_q.reg_write && rd_q == bus.id_rs2) ||
           (bus.mem_reg_write && bus.mem_rd == bus.id_rs2)))
        raw_hit = 1'b1;
    end
  end
`endif

  assign stall = load_use || raw_hit;

  // A flush always wins; a stall only injects a bubble if the stage advances
  assign kill = bus.flush || (!bus.hold && stall);

  // ID/EX register: bubbles clear every field so all EX outputs read zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= CTRL_BUBBLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (kill) begin
      ctrl_q     <= CTRL_BUBBLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (!bus.hold) begin
      ctrl_q.valid     <= bus.id_valid;
      ctrl_q.reg_write <= bus.id_reg_write;
      ctrl_q.mem_read  <= bus.id_mem_read;
      ctrl_q.mem_write <= bus.id_mem_write;
      ctrl_q.use_imm   <= bus.id_use_imm;
      ctrl_q.alu_ctrl  <= bus.id_alu_ctrl;
      rs1_q            <= bus.id_rs1;
      rs2_q            <= bus.id_rs2;
      rd_q             <= bus.id_rd;
      rs1_data_q       <= bus.id_rs1_data;
      rs2_data_q       <= bus.id_rs2_data;
      imm_q            <= bus.id_imm;
    end
  end

  assign bus.ex_a          = rs1_byp;
  assign bus.ex_b          = ctrl_q.use_imm ? imm_q : rs2_byp;
  assign bus.ex_store_data = rs2_byp;
  assign bus.ex_alu_ctrl   = ctrl_q.alu_ctrl;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.hazard_stall  = stall;

endmodule
